// File: rtl/comp_pkg.sv
// Shared types for the comparator and its successive-approximation initiator:
// flag bundle, one-hot check and the search FSM state encoding.
package comp_pkg;

    localparam int COMP_WIDTH = 16;
    localparam int SETTLE_W   = 4;

    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
    } cmp_flags_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_EVAL,
        ST_VERIFY_SETTLE,
        ST_VERIFY
    } sar_state_t;

    function automatic logic cmp_onehot(input cmp_flags_t f);
        return (f == 3'b100) || (f == 3'b010) || (f == 3'b001);
    endfunction

endpackage

// File: rtl/comp_settle_cnt.sv
// Loadable down-counter pacing the wait between driving a probe and sampling flags.
// zero_o marks the decrement that empties the count, so the FSM leaves on that cycle.
module comp_settle_cnt
    import comp_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  logic [SETTLE_W-1:0] load_val_i,
    input  logic                dec_i,
    output logic                zero_o
);

    logic [SETTLE_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q <= SETTLE_W'(1));

endmodule

// File: rtl/comp_sar_search.sv
// MSB-first successive-approximation search that recovers a comparator's B operand
// by driving probe values on A and reading back the lt/eq/gt flags.
module comp_sar_search
    import comp_pkg::*;
#(
    parameter int WIDTH   = COMP_WIDTH,
    parameter int CMP_LAT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic [WIDTH-1:0] probe,
    input  logic             cmp_lt,
    input  logic             cmp_eq,
    input  logic             cmp_gt,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             found,
    output logic             err
);

    localparam int IDX_W = $clog2(WIDTH);

    sar_state_t       state_q, state_d;
    logic [WIDTH-1:0] probe_q, probe_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             found_q, found_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] decided;
    logic             cnt_load, cnt_dec, cnt_zero;
    cmp_flags_t       flags;

    assign flags = '{lt: cmp_lt, eq: cmp_eq, gt: cmp_gt};

    comp_settle_cnt u_settle (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (SETTLE_W'(CMP_LAT)),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        probe_d  = probe_q;
        result_d = result_q;
        idx_d    = idx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        found_d  = found_q;
        err_d    = err_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        decided  = probe_q;
        if (flags.gt) begin
            decided[idx_q] = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    probe_d  = {1'b1, {(WIDTH-1){1'b0}}};
                    idx_d    = IDX_W'(WIDTH-1);
                    cnt_load = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = (CMP_LAT > 0) ? ST_SETTLE : ST_EVAL;
                end
            end
            ST_SETTLE: begin
                cnt_dec = 1'b1;
                if (cnt_zero) state_d = ST_EVAL;
            end
            ST_VERIFY_SETTLE: begin
                cnt_dec = 1'b1;
                if (cnt_zero) state_d = ST_VERIFY;
            end
            ST_EVAL: begin
                if (!cmp_onehot(flags) || flags.eq) begin
                    // Early exit: either a confirmed match or a broken flag set.
                    state_d  = ST_IDLE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    result_d = probe_q;
                    found_d  = cmp_onehot(flags);
                    err_d    = !cmp_onehot(flags);
                end else begin
                    cnt_load = 1'b1;
                    if (idx_q != '0) begin
                        decided[idx_q - 1'b1] = 1'b1;
                        idx_d   = idx_q - 1'b1;
                        state_d = (CMP_LAT > 0) ? ST_SETTLE : ST_EVAL;
                    end else begin
                        state_d = (CMP_LAT > 0) ? ST_VERIFY_SETTLE : ST_VERIFY;
                    end
                    probe_d = decided;
                end
            end
            ST_VERIFY: begin
                state_d  = ST_IDLE;
                busy_d   = 1'b0;
                done_d   = 1'b1;
                result_d = probe_q;
                found_d  = cmp_onehot(flags) && flags.eq;
                err_d    = !cmp_onehot(flags);
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            probe_q  <= '0;
            result_q <= '0;
            idx_q    <= IDX_W'(WIDTH-1);
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            probe_q  <= probe_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            found_q  <= found_d;
            err_q    <= err_d;
        end
    end

    assign busy   = busy_q;
    assign probe  = probe_q;
    assign done   = done_q;
    assign result = result_q;
    assign found  = found_q;
    assign err    = err_q;

endmodule

// File: tb/tb_comp_sar_search.sv
// Three searchers (settle latency 0, 1, 2) each answered by a behavioural comparator
// with a matching flag pipeline; expected outcomes are queued and checked on done.
module tb_comp_sar_search;

    typedef struct {
        int          inst;
        logic [15:0] result;
        logic        found;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_s  [3];
    logic        busy_s   [3];
    logic [15:0] probe_s  [3];
    logic [15:0] target_s [3];
    logic        bad_s    [3];
    logic [2:0]  fl_s     [3];
    logic        done_s   [3];
    logic [15:0] result_s [3];
    logic        found_s  [3];
    logic        err_s    [3];

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;
    int   start_edge [3];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_inst
            logic [2:0] raw;
            // lt/eq/gt from a behavioural compare, with an optional illegal flag set.
            assign raw = (bad_s[gi] && probe_s[gi] == 16'hE000) ? 3'b101 :
                         {probe_s[gi] < target_s[gi], probe_s[gi] == target_s[gi],
                          probe_s[gi] > target_s[gi]};
            if (gi == 0) begin : g_direct
                assign fl_s[gi] = raw;
            end else begin : g_pipe
                logic [2:0] pipe_q [gi];
                always @(posedge clk) begin
                    pipe_q[0] <= raw;
                    for (int k = 1; k < gi; k++) pipe_q[k] <= pipe_q[k-1];
                end
                assign fl_s[gi] = pipe_q[gi-1];
            end

            comp_sar_search #(.WIDTH(16), .CMP_LAT(gi)) dut (
                .clk    (clk),
                .rst    (rst),
                .start  (start_s[gi]),
                .busy   (busy_s[gi]),
                .probe  (probe_s[gi]),
                .cmp_lt (fl_s[gi][2]),
                .cmp_eq (fl_s[gi][1]),
                .cmp_gt (fl_s[gi][0]),
                .done   (done_s[gi]),
                .result (result_s[gi]),
                .found  (found_s[gi]),
                .err    (err_s[gi])
            );
        end
    endgenerate

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Record the edge on which each searcher accepts a start.
    always @(posedge clk) begin
        edge_cnt++;
        for (int i = 0; i < 3; i++)
            if (!rst && start_s[i] && !busy_s[i]) start_edge[i] = edge_cnt;
    end

    // Monitor: one line per completed search.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (done_s[i] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done inst=%0d result=%h required no done", i, result_s[i]);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("txn inst=%0d result=%h found=%0d err=%0d lat=%0d",
                             i, result_s[i], found_s[i], err_s[i], edge_cnt - start_edge[i] + 1);
                    chk("inst", i, e.inst);
                    chk("result", int'(result_s[i]), int'(e.result));
                    chk("found", int'(found_s[i]), int'(e.found));
                    chk("err", int'(err_s[i]), int'(e.err));
                    chk("latency", edge_cnt - start_edge[i] + 1, e.lat);
                    chk("busy_at_done", int'(busy_s[i]), 0);
                end
            end
        end
    end

    task automatic push(input int inst, input logic [15:0] res, input logic fnd,
                        input logic er, input int lat);
        exp_t e;
        e.inst = inst; e.result = res; e.found = fnd; e.err = er; e.lat = lat;
        exp_q.push_back(e);
    endtask

    // Returns #1 after the edge that raised done, i.e. inside the done cycle.
    task automatic wait_done(input int inst, input int budget);
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            #1;
            if (done_s[inst]) return;
        end
        checks++;
        errors++;
        $display("FAIL timeout inst=%0d actual=no done required=done within %0d cycles", inst, budget);
    endtask

    task automatic run(input int inst, input logic [15:0] tgt, input logic [15:0] res,
                       input logic fnd, input logic er, input int lat);
        @(negedge clk);
        target_s[inst] = tgt;
        push(inst, res, fnd, er, lat);
        start_s[inst] = 1'b1;
        @(negedge clk);
        start_s[inst] = 1'b0;
        wait_done(inst, 200);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_s[i] = 1'b0; target_s[i] = 16'h0; bad_s[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_busy", int'(busy_s[i]), 0);
            chk("rst_probe", int'(probe_s[i]), 0);
            chk("rst_done", int'(done_s[i]), 0);
            chk("rst_result", int'(result_s[i]), 0);
            chk("rst_found", int'(found_s[i]), 0);
            chk("rst_err", int'(err_s[i]), 0);
        end
        rst = 1'b0;

        run(0, 16'h8000, 16'h8000, 1'b1, 1'b0, 2);
        run(1, 16'h0000, 16'h0000, 1'b1, 1'b0, 35);
        run(1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 33);
        bad_s[0] = 1'b1;
        run(0, 16'hFFFF, 16'hE000, 1'b0, 1'b1, 4);
        bad_s[0] = 1'b0;

        // Reset in the middle of a search: no done, outputs back to reset values.
        @(negedge clk);
        target_s[2] = 16'h1234;
        start_s[2] = 1'b1;
        @(negedge clk);
        start_s[2] = 1'b0;
        repeat (9) @(negedge clk);
        chk("busy_before_abort", int'(busy_s[2]), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", int'(busy_s[2]), 0);
        chk("abort_probe", int'(probe_s[2]), 0);
        chk("abort_done", int'(done_s[2]), 0);
        chk("abort_result", int'(result_s[2]), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        run(2, 16'h1234, 16'h1234, 1'b1, 1'b0, 43);

        // Back-to-back with start held high throughout.
        @(negedge clk);
        target_s[0] = 16'h00FF;
        push(0, 16'h00FF, 1'b1, 1'b0, 17);
        push(0, 16'hAAAA, 1'b1, 1'b0, 16);
        start_s[0] = 1'b1;
        wait_done(0, 100);
        target_s[0] = 16'hAAAA;
        wait_done(0, 100);
        start_s[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("no_restart_busy", int'(busy_s[0]), 0);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/comp_sar_search.md
Name: comp_sar_search

Overview:
- Sequential initiator for the 16-bit three-way magnitude comparator (`comp`). That comparator is purely combinational and answers "A vs B" on lt/eq/gt flags.
- This block drives operand A (`probe`) and consumes the three flags. Operand B (`target`) is supplied by the environment.
- It runs an MSB-first successive-approximation search and reports the value of B plus whether it was confirmed equal.
- Used as a self-checking harness and as a B-to-binary recovery engine wherever B is reachable only through a comparator.

Parameters:
- WIDTH, 16, operand width in bits (comparator width).
- CMP_LAT, 0, settle cycles inserted between driving `probe` and sampling flags. Range 0..15. Covers registered or off-chip comparators.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin search. Sampled only in IDLE.
- busy  out  1  high while a search is in progress
- probe  out  WIDTH  operand A driven to the comparator
- cmp_lt  in  1  comparator flag: probe < target
- cmp_eq  in  1  comparator flag: probe == target
- cmp_gt  in  1  comparator flag: probe > target
- done  out  1  one-cycle pulse: `result`/`found`/`err` are valid
- result  out  WIDTH  search outcome. Held until the next accepted `start`.
- found  out  1  final probe was confirmed equal (`cmp_eq`)
- err  out  1  flags were not one-hot at a sample point

Behaviour:
- Reset: state IDLE. `busy`=0, `probe`=0, `done`=0, `result`=0, `found`=0, `err`=0, bit index=WIDTH-1, settle counter=0.
- Reset during a search aborts it immediately. No `done` is produced.
- States: IDLE, SETTLE, EVAL, VERIFY_SETTLE, VERIFY.
- IDLE:
  - `start`=1 loads `probe` = 1<<(WIDTH-1), index=WIDTH-1, counter=CMP_LAT.
  - `busy` rises on the same edge.
  - Next state is SETTLE if CMP_LAT>0, otherwise EVAL.
- SETTLE: decrement the counter. When it reaches 1, go to EVAL. `probe` is stable throughout.
- EVAL: sample the flags in this cycle only.
  - Not exactly one flag high: finish with `err`=1, `found`=0, `result`=`probe`.
  - `cmp_eq`: finish with `found`=1, `result`=`probe` (early exit).
  - `cmp_gt`: clear `probe`[index].
  - `cmp_lt`: keep `probe`[index].
  - If index>0: decrement index, set the new `probe`[index], and go to SETTLE (CMP_LAT>0) or EVAL.
  - If index==0: go to VERIFY_SETTLE (CMP_LAT>0) or VERIFY, with the decided `probe`.
- VERIFY: one final comparison of the fully decided `probe`.
  - `cmp_eq` gives `found`=1. Otherwise `found`=0.
  - Not one-hot gives `err`=1.
  - `result`=`probe` in all cases.
- Finish:
  - On the finishing edge the FSM returns to IDLE, `done`=1 for exactly one cycle, and `busy`=0.
  - `result`/`found`/`err` update on that same edge.
  - `probe` holds its final value until the next `start`.
- `start` in the `done` cycle is accepted, because the FSM is IDLE. `start` while `busy` is ignored.
- Latency: N comparisons used (1..WIDTH+1). `done` is visible N*(CMP_LAT+1)+1 cycles after the `start` edge.
  - Max N=WIDTH+1, reached only when target=0.
- If `target` changes mid-search, `found`=0 is a legal outcome. `result` is still the last probe. There is no `err` unless the flags are non-one-hot.
- Flags are ignored outside EVAL and VERIFY.

Decomposition:
- Shared package comp_pkg:
  - COMP_WIDTH=16.
  - Typedef `cmp_flags_t` {lt,eq,gt}.
  - Function `cmp_onehot()`.
  - FSM state enum `sar_state_t`.
- Sub-module comp_settle_cnt: a loadable down-counter with a zero flag, used by SETTLE and VERIFY_SETTLE.
- The bench instantiates `comp` (plus an optional CMP_LAT-deep flag pipeline) as the responder.

Test Plan:
- CMP_LAT=0, target=0x8000, pulse start:
  - first EVAL sees eq.
  - `done` at cycle 2 with `result`=0x8000, `found`=1, `err`=0.
- CMP_LAT=1, target=0x0000:
  - probes 0x8000,0x4000,...,0x0001 all gt, then VERIFY of 0x0000 gives eq.
  - N=17, `done` at cycle 35, `result`=0, `found`=1.
- CMP_LAT=1, target=0xFFFF:
  - probes 0x8000,0xC000,... all lt; probe 0xFFFF at bit 0 gives eq.
  - N=16, `done` at cycle 33, `result`=0xFFFF, `found`=1.
- CMP_LAT=0, force flags lt=1,gt=1 on the 3rd EVAL:
  - `done` at cycle 4, `err`=1, `found`=0, `result`=0xE000.
- CMP_LAT=2, target=0x1234, assert rst at cycle 10:
  - all outputs return to their reset values the next cycle, with no `done`.
  - A fresh start then gives `result`=0x1234, `found`=1.
- Back-to-back: start held high continuously with targets 0x00FF then 0xAAAA:
  - second search accepted in the `done` cycle.
  - `start` pulses while `busy` have no effect.
  - both report the correct `result` with `found`=1.
